// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the register-file write-back block.
//   WB_XLEN / WB_REG_ADDR_W : default data width and register address width
//   src_t                   : source encoding (MEM = 0, ALU = 1); the encoding
//                             doubles as the bit index into the 2-bit req/gnt
//                             vectors of the arbiter
//   REG_ZERO                : the hard-wired zero register, never written
// ----------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_XLEN       = 32;
    localparam int WB_REG_ADDR_W = 5;

    typedef enum logic {
        SRC_MEM = 1'b0,
        SRC_ALU = 1'b1
    } src_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-request round-robin arbiter with a one-bit priority pointer.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low (0 = in reset)
//   req   : request vector, bit index = src_t encoding (0 = MEM, 1 = ALU)
//   gnt   : one-hot (or zero) grant, combinational from req and the pointer
// The pointer starts at MEM and flips only after a contested cycle, so under
// continuous contention the grants strictly alternate. Grants are held low
// while reset is asserted so nothing is handshaken during reset.
// ----------------------------------------------------------------------------
module rr_arbiter2
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    src_t ptr_reg;
    src_t ptr_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg <= SRC_MEM;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    always_comb begin
        gnt      = 2'b00;
        ptr_next = ptr_reg;
        if (reset) begin
            if (req == 2'b11) begin
                // Contested: pointer picks the winner, then hands priority
                // to the loser for the next contest.
                if (ptr_reg == SRC_MEM) begin
                    gnt      = 2'b01;
                    ptr_next = SRC_ALU;
                end else begin
                    gnt      = 2'b10;
                    ptr_next = SRC_MEM;
                end
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// ----------------------------------------------------------------------------
// wb_arbiter
// Write-back stage of the register file: merges ALU and load results through
// valid/ready handshakes, round-robin arbitrated, into one registered write
// port. Writes to x0 are handshaken but never enabled. A saturating counter
// records cycles in which both sources were valid.
//
// Optional build macro: WB_FWD_EN adds a two-port forwarding path from the
// output register (fwd_rs1/2 in, fwd_hit1/2 and fwd_data1/2 out).
//
// Ports:
//   clk, reset                : clock; asynchronous active-low reset
//   alu_valid/rd/data, ready  : ALU result handshake
//   mem_valid/rd/data, ready  : load result handshake
//   rf_we, rf_dest, rf_data   : register-file write port (1-cycle latency)
//   fwd_*                     : forwarding lookups (WB_FWD_EN only)
//   conflict_cnt              : saturating count of contested cycles
// ----------------------------------------------------------------------------
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN       = WB_XLEN,
    parameter int REG_ADDR_W = WB_REG_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    output logic                  mem_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_dest,
    output logic [XLEN-1:0]       rf_data,
`ifdef WB_FWD_EN
    input  logic [REG_ADDR_W-1:0] fwd_rs1,
    input  logic [REG_ADDR_W-1:0] fwd_rs2,
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [XLEN-1:0]       fwd_data1,
    output logic [XLEN-1:0]       fwd_data2,
`endif
    output logic [CNT_W-1:0]      conflict_cnt
);

    logic [1:0]            req;
    logic [1:0]            gnt;
    logic                  granted;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    always_comb begin
        req          = 2'b00;
        req[SRC_MEM] = mem_valid;
        req[SRC_ALU] = alu_valid;
    end

    rr_arbiter2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt)
    );

    assign mem_ready = gnt[SRC_MEM];
    assign alu_ready = gnt[SRC_ALU];
    assign granted   = |gnt;

    // Grant is one-hot when non-zero, so a two-way mux on the ALU bit suffices.
    assign sel_rd   = gnt[SRC_ALU] ? alu_rd   : mem_rd;
    assign sel_data = gnt[SRC_ALU] ? alu_data : mem_data;

    // Output register: address and data are captured on every grant (even for
    // x0) but only a non-zero destination raises the write enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we   <= 1'b0;
            rf_dest <= '0;
            rf_data <= '0;
        end else if (granted) begin
            rf_we   <= (sel_rd != REG_ADDR_W'(REG_ZERO));
            rf_dest <= sel_rd;
            rf_data <= sel_data;
        end else begin
            rf_we   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt <= '0;
        end else if (mem_valid && alu_valid && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

`ifdef WB_FWD_EN
    logic [REG_ADDR_W-1:0] fwd_rs  [2];
    logic                  fwd_hit [2];
    logic [XLEN-1:0]       fwd_val [2];

    assign fwd_rs[0] = fwd_rs1;
    assign fwd_rs[1] = fwd_rs2;

    // Forward the value currently being written; data is zeroed on a miss so
    // consumers can OR it without qualifying by the hit bit.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign fwd_hit[gi] = rf_we && (rf_dest == fwd_rs[gi]);
        assign fwd_val[gi] = fwd_hit[gi] ? rf_data : '0;
    end

    assign fwd_hit1  = fwd_hit[0];
    assign fwd_hit2  = fwd_hit[1];
    assign fwd_data1 = fwd_val[0];
    assign fwd_data2 = fwd_val[1];
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed bench for wb_arbiter (instantiated with CNT_W = 4 so saturation is
// reachable quickly). Registered outputs are sampled 1 time unit after the
// rising edge; ready outputs are sampled 1 time unit after inputs change.
// Build with WB_FWD_EN defined to include the forwarding checks.
// ----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 4;

    logic                  clk;
    logic                  reset;
    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  alu_ready;
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [XLEN-1:0]       mem_data;
    logic                  mem_ready;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_dest;
    logic [XLEN-1:0]       rf_data;
    logic [CNT_W-1:0]      conflict_cnt;
`ifdef WB_FWD_EN
    logic [REG_ADDR_W-1:0] fwd_rs1;
    logic [REG_ADDR_W-1:0] fwd_rs2;
    logic                  fwd_hit1;
    logic                  fwd_hit2;
    logic [XLEN-1:0]       fwd_data1;
    logic [XLEN-1:0]       fwd_data2;
`endif

    int tests = 0;
    int fails = 0;

    wb_arbiter #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .rf_we        (rf_we),
        .rf_dest      (rf_dest),
        .rf_data      (rf_data),
`ifdef WB_FWD_EN
        .fwd_rs1      (fwd_rs1),
        .fwd_rs2      (fwd_rs2),
        .fwd_hit1     (fwd_hit1),
        .fwd_hit2     (fwd_hit2),
        .fwd_data1    (fwd_data1),
        .fwd_data2    (fwd_data2),
`endif
        .conflict_cnt (conflict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        $display("[TB] %s obs=%0h exp=%0h", tag, obs, exp);
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        alu_valid = 1'b1;
        alu_rd    = 5'd10;
        alu_data  = 32'h0000_00AA;
        mem_valid = 1'b1;
        mem_rd    = 5'd9;
        mem_data  = 32'h0000_0099;
`ifdef WB_FWD_EN
        fwd_rs1   = 5'd7;
        fwd_rs2   = 5'd3;
`endif
        #2 reset = 1'b0;

        // Reset held with both sources valid
        repeat (3) tick();
        chk("rst_we", rf_we, 0);
        chk("rst_dest", rf_dest, 0);
        chk("rst_data", rf_data, 0);
        chk("rst_cnt", conflict_cnt, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);

        // Release: first contested grant goes to MEM, no write yet
        reset = 1'b1;
        #1;
        chk("first_mem_ready", mem_ready, 1);
        chk("first_alu_ready", alu_ready, 0);
        chk("first_no_write", rf_we, 0);

        tick();
        chk("c0_we", rf_we, 1);
        chk("c0_dest", rf_dest, 9);
        chk("c0_data", rf_data, 32'h99);
        chk("c0_cnt", conflict_cnt, 1);
        // MEM presents a new result; ALU held -> contested, pointer now ALU
        mem_rd   = 5'd11;
        mem_data = 32'h0000_00BB;
        #1;
        chk("c1_alu_ready", alu_ready, 1);
        chk("c1_mem_ready", mem_ready, 0);

        tick();
        chk("c1_dest", rf_dest, 10);
        chk("c1_data", rf_data, 32'hAA);
        chk("c1_cnt", conflict_cnt, 2);
        alu_valid = 1'b0;
        #1;
        chk("c2_mem_ready", mem_ready, 1);
        chk("c2_alu_ready", alu_ready, 0);

        tick();
        chk("c2_we", rf_we, 1);
        chk("c2_dest", rf_dest, 11);
        chk("c2_cnt", conflict_cnt, 2);

        // Single ALU source
        mem_valid = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEAD_BEEF;
        #1;
        chk("single_alu_ready", alu_ready, 1);
        chk("single_mem_ready", mem_ready, 0);
        tick();
        alu_valid = 1'b0;
        chk("single_we", rf_we, 1);
        chk("single_dest", rf_dest, 5);
        chk("single_data", rf_data, 32'hDEAD_BEEF);
        tick();
        chk("single_we_off", rf_we, 0);
        chk("single_dest_hold", rf_dest, 5);
        chk("single_data_hold", rf_data, 32'hDEAD_BEEF);

        // Contention for 4 cycles: pointer is MEM, expect rd1, rd2, rd1, rd2
        mem_valid = 1'b1;
        mem_rd    = 5'd1;
        mem_data  = 32'h11;
        alu_valid = 1'b1;
        alu_rd    = 5'd2;
        alu_data  = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("cont%0d_mem_ready", i), mem_ready, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("cont%0d_alu_ready", i), alu_ready, (i % 2 == 0) ? 0 : 1);
            tick();
            chk($sformatf("cont%0d_dest", i), rf_dest, (i % 2 == 0) ? 1 : 2);
            chk($sformatf("cont%0d_data", i), rf_data, (i % 2 == 0) ? 32'h11 : 32'h22);
            chk($sformatf("cont%0d_we", i), rf_we, 1);
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        chk("cont_cnt", conflict_cnt, 6);

        // x0 destination: handshaken, not written
        mem_valid = 1'b1;
        mem_rd    = 5'd0;
        mem_data  = 32'hFFFF_FFFF;
        #1;
        chk("x0_mem_ready", mem_ready, 1);
        tick();
        mem_valid = 1'b0;
        chk("x0_we", rf_we, 0);
        chk("x0_dest", rf_dest, 0);
        chk("x0_data", rf_data, 32'hFFFF_FFFF);

`ifdef WB_FWD_EN
        // Forwarding: rd7 written, rs1 hits, rs2 misses
        alu_valid = 1'b1;
        alu_rd    = 5'd7;
        alu_data  = 32'h1234;
        tick();
        alu_valid = 1'b0;
        #1;
        chk("fwd_we", rf_we, 1);
        chk("fwd_hit1", fwd_hit1, 1);
        chk("fwd_data1", fwd_data1, 32'h1234);
        chk("fwd_hit2", fwd_hit2, 0);
        chk("fwd_data2", fwd_data2, 0);
        tick();
        chk("fwd_hit1_off", fwd_hit1, 0);
        chk("fwd_data1_off", fwd_data1, 0);
`endif

        // Saturation: counter at 6, 21 contested cycles (pointer ends at ALU)
        mem_valid = 1'b1;
        mem_rd    = 5'd1;
        alu_valid = 1'b1;
        alu_rd    = 5'd2;
        repeat (5) tick();
        chk("sat_mid_cnt", conflict_cnt, 11);
        repeat (15) tick();
        chk("sat_cnt", conflict_cnt, 15);
        tick();
        chk("sat_hold_cnt", conflict_cnt, 15);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        tick();
        chk("sat_idle_cnt", conflict_cnt, 15);

        // Mid-transfer reset: pointer is ALU before reset, MEM after
        alu_valid = 1'b1;
        alu_rd    = 5'd4;
        alu_data  = 32'h44;
        mem_valid = 1'b1;
        mem_rd    = 5'd3;
        mem_data  = 32'h33;
        #1;
        chk("pre_rst_alu_ready", alu_ready, 1);
        chk("pre_rst_mem_ready", mem_ready, 0);
        reset = 1'b0;
        #1;
        chk("mid_rst_alu_ready", alu_ready, 0);
        chk("mid_rst_cnt", conflict_cnt, 0);
        tick();
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_dest", rf_dest, 0);
        chk("mid_rst_data", rf_data, 0);
        reset = 1'b1;
        #1;
        chk("post_rst_mem_ready", mem_ready, 1);
        chk("post_rst_alu_ready", alu_ready, 0);
        chk("post_rst_no_write", rf_we, 0);
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        chk("post_rst_we", rf_we, 1);
        chk("post_rst_dest", rf_dest, 3);
        chk("post_rst_data", rf_data, 32'h33);
        chk("post_rst_cnt", conflict_cnt, 1);
        tick();
        chk("final_we_off", rf_we, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
